c2b_serial: RTL
===============

Name: c2b_serial

Overview:
- Bit-serial converter from two's-complement back to sign-magnitude (binary) form: the return path of the multiplier's binary-to-complement stage.
- Takes a WIDTH-bit signed operand or product on a valid/ready input.
- Converts LSB-first, one bit per clock, using the "copy through first 1, then invert" rule.
- Presents sign plus unsigned magnitude on a valid/ready output. Sits between the MACC multiplier core and the sign-magnitude consumers.

Parameters:
- WIDTH, 4, data width of the two's-complement input and of the magnitude output (legal range 2..32).
- CW, $clog2(WIDTH+1), width of the internal bit counter (derived; not to be overridden).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept an operand (high only in IDLE).
- in_data  input  WIDTH  two's-complement operand.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- out_sign  output  1  sign of result (1 = negative).
- out_mag  output  WIDTH  unsigned magnitude.
- out_zero  output  1  magnitude equals 0.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_sign=0, out_mag=0, out_zero=0, busy=0, counter=0, shift registers=0. Release is synchronous to clk.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&&in_ready: latch in_data into the shift register, sign_r=in_data[WIDTH-1], seen_one=0, cnt=0, then go to SHIFT.
- SHIFT (one bit per edge, LSB first):
  - b = shift_reg[0].
  - Output bit = b if sign_r=0 or seen_one=0; otherwise ~b.
  - seen_one |= b.
  - Shift the output bit into mag_r from the MSB side (after WIDTH shifts mag_r[0] holds the original LSB).
  - cnt increments; after the WIDTH-th edge (cnt reaches WIDTH), go to DONE.
  - Positive operands still take WIDTH cycles, so latency is constant.
- DONE:
  - out_valid=1; out_sign=sign_r; out_mag=mag_r; out_zero=(mag_r==0).
  - Outputs are held stable while out_ready=0.
  - On an edge with out_valid&&out_ready: go to IDLE and clear out_valid.
  - in_ready stays 0 in DONE; no same-cycle accept.
- Latency and throughput:
  - Input handshake at edge k gives out_valid=1 after edge k+WIDTH.
  - Minimum issue interval is WIDTH+2 cycles.
- Width rules:
  - The most-negative input -2^(WIDTH-1) yields out_sign=1, out_mag=2^(WIDTH-1). This fits unsigned WIDTH bits with no overflow.
  - Zero yields out_sign=0, out_zero=1. A negative zero is never produced.
- Input-side edge cases: in_valid asserted during SHIFT/DONE is ignored (in_ready=0), and in_data changes after acceptance have no effect.
- Reset mid-operation: rst_n low in SHIFT or DONE aborts immediately. out_valid drops asynchronously and the partial result is discarded.
- out_valid must never assert without a preceding accepted input.

Test Plan:
- WIDTH=4, in_data=4'b1011 (-5), out_ready=1 -> out_valid after exactly 4 cycles; out_sign=1, out_mag=4'b0101, out_zero=0.
- in_data=4'b1000 (-8) -> out_sign=1, out_mag=4'b1000. in_data=4'b1111 (-1) -> out_sign=1, out_mag=4'b0001.
- in_data=4'b0111 -> out_sign=0, out_mag=4'b0111 after 4 cycles. in_data=4'b0000 -> out_sign=0, out_mag=0, out_zero=1.
- Exhaustive sweep of all 16 inputs with a random out_ready stall of 0-5 cycles:
  - out_mag, out_sign stay stable while stalled.
  - out_sign ? -out_mag : out_mag equals the signed input.
  - in_ready=0 throughout.
- Back-to-back in_valid held high with out_ready=1 -> accepts spaced exactly 6 cycles apart (WIDTH+2); a new in_data presented during SHIFT is not captured.
- Assert rst_n=0 two cycles into SHIFT on -3 -> out_valid=0, busy=0, in_ready=1 immediately. After release, converting 4'b0010 gives out_sign=0, out_mag=4'b0010.

Source files
------------

// File: rtl/c2b_serial.sv
// c2b_serial: bit-serial two's-complement to sign-magnitude converter.
// It accepts a WIDTH-bit signed value and walks it LSB first, one bit per
// clock, using the "copy through the first 1, then invert" rule. It then
// presents sign plus unsigned magnitude until the consumer takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data carries an operand
//   in_ready   converter is idle and can take an operand
//   in_data    WIDTH-bit two's-complement operand
//   out_valid  result is available (DONE state)
//   out_ready  consumer takes the result
//   out_sign   result sign, 1 = negative
//   out_mag    unsigned magnitude
//   out_zero   magnitude is zero
//   busy       conversion in flight or result waiting
module c2b_serial #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_mag;
  logic             r_sign;
  logic             r_seenOne;
  logic [CW-1:0]    r_cnt;
  logic             w_accept;
  logic             w_lastShift;
  logic             w_outBit;

  assign w_accept    = (r_state == IDLE) && in_valid;
  assign w_lastShift = (r_cnt == CW'(WIDTH - 1));

  // A negative value is copied through its lowest 1 and inverted above it,
  // which is exactly two's-complement negation done one bit at a time.
  assign w_outBit = r_shift[0] ^ (r_sign & r_seenOne);

  // State register; reset aborts any conversion in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_nextState = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (w_lastShift) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath: load on accept, then shift one bit per clock. Positive values
  // also take the full WIDTH shifts so latency does not depend on the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_mag     <= '0;
      r_sign    <= 1'b0;
      r_seenOne <= 1'b0;
      r_cnt     <= '0;
    end else if (w_accept) begin
      r_shift   <= in_data;
      r_mag     <= '0;
      r_sign    <= in_data[WIDTH-1];
      r_seenOne <= 1'b0;
      r_cnt     <= '0;
    end else if (r_state == SHIFT) begin
      r_shift   <= r_shift >> 1;
      r_mag     <= {w_outBit, r_mag[WIDTH-1:1]};
      r_seenOne <= r_seenOne | r_shift[0];
      r_cnt     <= r_cnt + CW'(1);
    end
  end

  // Result fields are gated so nothing partial is visible outside DONE.
  // A zero input always has sign 0, so negative zero cannot appear.
  assign out_sign = out_valid & r_sign;
  assign out_mag  = out_valid ? r_mag : '0;
  assign out_zero = out_valid & (r_mag == '0);

endmodule
